// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation mode encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSR = 2'b00,
    SHIFT_ASR = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_LSL = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One register stage of the shifter: shifts by STEP when its shamt bit is set.
// Every stage holds together on !adv, so backpressure is a single global enable.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [$clog2(WIDTH)-1:0]   shamt_i,
  input  shift_mode_e                mode_i,
  input  logic                       sign_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(WIDTH)-1:0]   shamt_o,
  output shift_mode_e                mode_o,
  output logic                       sign_o,
  output logic [TAG_W-1:0]           tag_o
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int BIT     = $clog2(STEP);

  logic               valid_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q;
  shift_mode_e        mode_q;
  logic               sign_q;
  logic [TAG_W-1:0]   tag_q;

  // ASR fills from the operand's original MSB carried in sign_i, not from data_i,
  // because earlier stages may already have replaced data_i's top bit.
  always_comb begin
    data_d = data_i;
    if (shamt_i[BIT]) begin
      unique case (mode_i)
        SHIFT_LSR: data_d = {{STEP{1'b0}}, data_i[WIDTH-1:STEP]};
        SHIFT_ASR: data_d = {{STEP{sign_i}}, data_i[WIDTH-1:STEP]};
        SHIFT_ROR: data_d = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
        SHIFT_LSL: data_d = {data_i[WIDTH-1-STEP:0], {STEP{1'b0}}};
        default:   data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= SHIFT_LSR;
      sign_q  <= 1'b0;
      tag_q   <= '0;
    end else if (adv) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      mode_q  <= mode_i;
      sign_q  <= sign_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign mode_o  = mode_q;
  assign sign_o  = sign_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (LSR/ASR/ROR/LSL), one log2 stage per register, latency SHAMT_W.
// A single advance signal stalls the whole pipe when the output is held; bubbles are kept.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               adv;
  logic               valid_a [SHAMT_W+1];
  logic [WIDTH-1:0]   data_a  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_a [SHAMT_W+1];
  shift_mode_e        mode_a  [SHAMT_W+1];
  logic               sign_a  [SHAMT_W+1];
  logic [TAG_W-1:0]   tag_a   [SHAMT_W+1];
  logic               unused_tail;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign valid_a[0] = in_valid;
  assign data_a[0]  = in_data;
  assign shamt_a[0] = in_shamt;
  assign mode_a[0]  = shift_mode_e'(in_mode);
  assign sign_a[0]  = in_data[WIDTH-1];
  assign tag_a[0]   = in_tag;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STEP  (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .valid_i (valid_a[k]),
      .data_i  (data_a[k]),
      .shamt_i (shamt_a[k]),
      .mode_i  (mode_a[k]),
      .sign_i  (sign_a[k]),
      .tag_i   (tag_a[k]),
      .valid_o (valid_a[k+1]),
      .data_o  (data_a[k+1]),
      .shamt_o (shamt_a[k+1]),
      .mode_o  (mode_a[k+1]),
      .sign_o  (sign_a[k+1]),
      .tag_o   (tag_a[k+1])
    );
  end

  assign out_valid = valid_a[SHAMT_W];
  assign out_data  = data_a[SHAMT_W];
  assign out_tag   = tag_a[SHAMT_W];
  assign out_zero  = ~|data_a[SHAMT_W];

  // Control fields leaving the last stage have no consumer.
  assign unused_tail = ^{shamt_a[SHAMT_W], sign_a[SHAMT_W], 2'(mode_a[SHAMT_W])};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, streaming, stalls, random traffic, reset.
module tb_shift_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic          s_acc, s_emit, s_ov, s_oz, s_ir;
  logic [W-1:0]  s_od;
  logic [TW-1:0] s_ot;
  int            s_cyc;

  // Reference: plain arithmetic on the whole word.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'b00: r = d >> s;
      2'b01: r = $unsigned($signed(d) >>> s);
      2'b10: r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
      default: r = d << s;
    endcase
    return r;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                      input logic [1:0] m, input logic [TW-1:0] t, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_shamt = s; in_mode = m; in_tag = t; out_ready = ordy;
    #1;
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_ot = out_tag; s_oz = out_zero;
    s_cyc = cyc;
    s_acc = v && in_ready && !rst;
    s_emit = out_valid && ordy;
    if (s_acc) begin
      e.d = ref_shift(d, int'(s), m); e.t = t; e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, '0, '0, 2'b00, '0, 1'b0);
    checks++;
    if (s_ir !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", s_ir); end
    step(1'b0, '0, '0, 2'b00, '0, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    checks++;
    if (out_tag !== '0) begin errors++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
    checks++;
    if (out_zero !== 1'b1) begin errors++; $display("FAIL rst_out_zero: got %b want 1", out_zero); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after: got %b want 1", in_ready); end
    q.delete();
  endtask

  task automatic test_directed();
    logic [W-1:0]  vd [7] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000001,
                              32'h12345678, 32'h00000001, 32'h80000000};
    logic [SW-1:0] vs [7] = '{5'd4, 5'd4, 5'd4, 5'd1, 5'd0, 5'd31, 5'd1};
    logic [1:0]    vm [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [W-1:0]  vx [7] = '{32'h08000000, 32'hF8000000, 32'h04000000, 32'h80000000,
                              32'h12345678, 32'h80000000, 32'h00000000};
    int acc_cyc;
    bit got;
    for (int i = 0; i < 7; i++) begin
      q.delete();
      step(1'b1, vd[i], vs[i], vm[i], TW'(i), 1'b1);
      acc_cyc = s_cyc;
      checks++;
      if (s_acc !== 1'b1) begin errors++; $display("FAIL dir_accept[%0d]: got %b want 1", i, s_acc); end
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        step(1'b0, '0, '0, 2'b00, '0, 1'b1);
        if (s_emit) begin
          got = 1;
          checks++;
          if (s_od !== vx[i]) begin errors++; $display("FAIL dir_data[%0d]: got %h want %h", i, s_od, vx[i]); end
          checks++;
          if (s_oz !== (vx[i] == '0)) begin errors++; $display("FAIL dir_zero[%0d]: got %b want %b", i, s_oz, vx[i] == '0); end
          checks++;
          if (s_ot !== TW'(i)) begin errors++; $display("FAIL dir_tag[%0d]: got %h want %h", i, s_ot, TW'(i)); end
          checks++;
          if (s_cyc - acc_cyc != SW) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, s_cyc - acc_cyc, SW); end
        end
      end
      if (!got) begin checks++; errors++; $display("FAIL dir_timeout[%0d]: got no result want one", i); end
    end
    q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n_out = 0;
    int prev = -1;
    q.delete();
    for (int i = 0; i < 10 + 20; i++) begin
      if (i < 10) step(1'b1, $urandom, SW'($urandom), 2'($urandom), TW'(i), 1'b1);
      else        step(1'b0, '0, '0, 2'b00, '0, 1'b1);
      if (s_emit) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h want nothing", s_od); end
        else begin
          e = q.pop_front();
          if (s_od !== e.d || s_ot !== TW'(n_out) || s_ot !== e.t) begin
            errors++; $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", n_out, s_od, s_ot, e.d, TW'(n_out));
          end
        end
        if (prev >= 0) begin
          checks++;
          if (s_cyc != prev + 1) begin errors++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", n_out, s_cyc, prev + 1); end
        end
        prev = s_cyc;
        n_out++;
      end
    end
    checks++;
    if (n_out != 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", n_out); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [W-1:0]  hold_d;
    logic [TW-1:0] hold_t;
    int n_in = 0, n_out = 0;
    q.delete();
    for (int i = 0; i < 40; i++) begin
      logic ordy;
      logic v;
      ordy = !(i >= 7 && i < 10);
      v = (i < 14);
      step(v, $urandom, SW'($urandom), 2'($urandom), TW'(i), ordy);
      if (s_acc) n_in++;
      if (i == 7) begin hold_d = s_od; hold_t = s_ot; end
      if (i >= 7 && i < 10) begin
        checks++;
        if (s_ir !== 1'b0 || s_ov !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d]: got in_ready=%b out_valid=%b want 0/1", i, s_ir, s_ov); end
        checks++;
        if (s_od !== hold_d || s_ot !== hold_t) begin errors++; $display("FAIL bp_stable[%0d]: got %h/%h want %h/%h", i, s_od, s_ot, hold_d, hold_t); end
      end
      if (s_emit) begin
        n_out++;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want nothing", s_od); end
        else begin
          e = q.pop_front();
          if (s_od !== e.d || s_ot !== e.t || s_oz !== (e.d == '0)) begin
            errors++; $display("FAIL bp_data: got %h/%h/%b want %h/%h/%b", s_od, s_ot, s_oz, e.d, e.t, e.d == '0);
          end
        end
      end
    end
    checks++;
    if (n_out != n_in || q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d outputs want %0d", n_out, n_in); end
  endtask

  task automatic test_random();
    exp_t e;
    q.delete();
    for (int i = 0; i < 330; i++) begin
      logic v;
      logic ordy;
      v = (i < 300) && ($urandom_range(3) != 0);
      ordy = (i >= 300) || ($urandom_range(2) != 0);
      step(v, $urandom, SW'($urandom), 2'($urandom), TW'($urandom), ordy);
      if (s_emit) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_extra: got %h want nothing", s_od); end
        else begin
          e = q.pop_front();
          if (s_od !== e.d || s_ot !== e.t || s_oz !== (e.d == '0)) begin
            errors++; $display("FAIL rnd_data: got %h/%h/%b want %h/%h/%b", s_od, s_ot, s_oz, e.d, e.t, e.d == '0);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    bit got = 0;
    q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, SW'($urandom), 2'($urandom), TW'(i), 1'b1);
    rst = 1'b1;
    step(1'b0, '0, '0, 2'b00, '0, 1'b1);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 2'b00, '0, 1'b1);
      checks++;
      if (s_ov !== 1'b0) begin errors++; $display("FAIL mid_ghost[%0d]: got out_valid=%b want 0", i, s_ov); end
    end
    step(1'b1, 32'h80000000, 5'd4, 2'b01, 4'hA, 1'b1);
    for (int n = 0; n < 20 && !got; n++) begin
      step(1'b0, '0, '0, 2'b00, '0, 1'b1);
      if (s_emit) begin
        got = 1;
        e = q.pop_front();
        checks++;
        if (s_od !== 32'hF8000000 || s_ot !== 4'hA) begin errors++; $display("FAIL mid_data: got %h/%h want f8000000/a", s_od, s_ot); end
        checks++;
        if (s_cyc - e.cyc != SW) begin errors++; $display("FAIL mid_latency: got %0d want %0d", s_cyc - e.cyc, SW); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL mid_timeout: got no result want one"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
